// File: rtl/be8_datapath.sv
// BE8 datapath: architectural state, bus, ALU and RAM driven by the microcode control word.
// Build option BE8_BUS_CONFLICT_EN enables sticky detection of multiple simultaneous bus drivers.
module be8_datapath #(
   parameter bit RAM_INIT_ZERO = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [17:0] ctrl,
   input  logic        run,
   input  logic        prog_we,
   input  logic [3:0]  prog_addr,
   input  logic [7:0]  prog_data,
   output logic [3:0]  opcode,
   output logic [1:0]  flags,
   output logic [1:0]  step,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic        halted,
   output logic        bus_conflict
);

   logic hlt, ce, su, a_in, b_in, o_in, i_in, jmp, f_in, m_in, r_in;
   logic a_oe, b_oe, i_oe, c_oe, e_oe, r_oe, step_clr;

   assign hlt      = ctrl[17];
   assign ce       = ctrl[16];
   assign su       = ctrl[15];
   assign a_in     = ctrl[14];
   assign b_in     = ctrl[13];
   assign o_in     = ctrl[12];
   assign i_in     = ctrl[11];
   assign jmp      = ~ctrl[10];
   assign f_in     = ctrl[9];
   assign m_in     = ctrl[8];
   assign r_in     = ctrl[7];
   assign a_oe     = ~ctrl[6];
   assign b_oe     = ~ctrl[5];
   assign i_oe     = ~ctrl[4];
   assign c_oe     = ~ctrl[3];
   assign e_oe     = ~ctrl[2];
   assign r_oe     = ~ctrl[1];
   assign step_clr = ~ctrl[0];

   logic [7:0] a_q, b_q, ir_q, out_q;
   logic [3:0] pc_q, mar_q;
   logic       carry_q, zero_q, halt_q, ov_q;
   logic [1:0] step_q;
   logic [7:0] ram [16];
   logic       clr_busy;
   logic [3:0] clr_cnt;
   logic       exec;
   logic [7:0] bus;
   logic [8:0] alu_sum;

   assign exec = run & ~halt_q & ~clr_busy;

   // Subtraction is A + ~B + 1 so carry means "no borrow".
   assign alu_sum = {1'b0, a_q} + {1'b0, (su ? ~b_q : b_q)} + {8'h00, su};

   always_comb begin
      bus = 8'h00;
      if (a_oe) bus = bus | a_q;
      if (b_oe) bus = bus | b_q;
      if (i_oe) bus = bus | {4'h0, ir_q[3:0]};
      if (c_oe) bus = bus | {4'h0, pc_q};
      if (e_oe) bus = bus | alu_sum[7:0];
      if (r_oe) bus = bus | ram[mar_q];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         ir_q    <= 8'h00;
         out_q   <= 8'h00;
         pc_q    <= 4'h0;
         mar_q   <= 4'h0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         step_q  <= 2'd0;
         halt_q  <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         ov_q <= exec & o_in;
         if (exec) begin
            if (a_in) a_q   <= bus;
            if (b_in) b_q   <= bus;
            if (o_in) out_q <= bus;
            if (i_in) ir_q  <= bus;
            if (m_in) mar_q <= bus[3:0];
            if (f_in) begin
               carry_q <= alu_sum[8];
               zero_q  <= (alu_sum[7:0] == 8'h00);
            end
            if (jmp)     pc_q <= bus[3:0];
            else if (ce) pc_q <= pc_q + 4'd1;
            if (step_clr) step_q <= 2'd0;
            else          step_q <= step_q + 2'd1;
            if (hlt) halt_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clr_busy <= RAM_INIT_ZERO;
         clr_cnt  <= 4'h0;
      end else if (clr_busy) begin
         clr_cnt <= clr_cnt + 4'd1;
         if (clr_cnt == 4'hF) clr_busy <= 1'b0;
      end
   end

   // The write address is the pre-edge MAR, so RI with MIn stores to the old location.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (clr_busy)               ram[clr_cnt]   <= 8'h00;
         else if (exec && r_in)      ram[mar_q]     <= bus;
         else if (!run && prog_we)   ram[prog_addr] <= prog_data;
      end
   end

`ifdef BE8_BUS_CONFLICT_EN
   logic [2:0] drv_cnt;
   logic       conf_q;

   always_comb begin
      drv_cnt = 3'(a_oe) + 3'(b_oe) + 3'(i_oe) + 3'(c_oe) + 3'(e_oe) + 3'(r_oe);
   end

   always_ff @(posedge clk) begin
      if (rst)                          conf_q <= 1'b0;
      else if (exec && drv_cnt >= 3'd2) conf_q <= 1'b1;
   end

   assign bus_conflict = conf_q;
`else
   assign bus_conflict = 1'b0;
`endif

   assign opcode    = ir_q[7:4];
   assign flags     = {carry_q, zero_q};
   assign step      = step_q;
   assign out_data  = out_q;
   assign out_valid = ov_q;
   assign halted    = halt_q;

endmodule

// File: doc/be8_datapath.md
Name: be8_datapath

Overview:
- Execution side of the BE8 microcoded 8-bit CPU.
- Consumes the 18-bit control word produced by the microcode ROM and holds all architectural state: A, B, IR, PC, MAR, a 16x8 RAM, an output register and carry/zero flags.
- Closes the control loop by returning OPCODE, FLAGS and STEP to the ROM.
- Sits between the microcode ROM and the top-level pin mux.

Parameters:
- RAM_INIT_ZERO, 0, when 1 the RAM is cleared on reset (16 cycles, run ignored meanwhile); when 0 RAM contents survive reset.

Ports:
- clk  in  1  system clock, all state updates on its rising edge
- rst  in  1  synchronous reset, active-high
- ctrl  in  18  control word: [17]HLT [16]CE [15]SU [14]AIn [13]BIn [12]OIn [11]IIn [10]Jn [9]FIn [8]MIn [7]RI [6]AOn [5]BOn [4]IOn [3]COn [2]EOn [1]ROn [0]NOn. Signals with an n suffix are active-low; all others are active-high.
- run  in  1  1 = execute; 0 = freeze all CPU state and enable the program port
- prog_we  in  1  program-port RAM write strobe
- prog_addr  in  4  program-port address
- prog_data  in  8  program-port write data
- opcode  out  4  IR[7:4], to ROM OPCODE
- flags  out  2  {carry, zero}, to ROM FLAGS
- step  out  2  micro-step counter, to ROM STEP
- out_data  out  8  output register
- out_valid  out  1  one-cycle pulse after OIn loads
- halted  out  1  sticky halt
- bus_conflict  out  1  sticky multiple-driver flag (see Optional Feature)

Behaviour:
- Reset (rst=1 at an edge) sets:
  - A, B, IR, PC, MAR, OUT, flags, step = 0
  - halted = 0, out_valid = 0, bus_conflict = 0
  - Reset has priority over every other input, including mid-instruction and while halted.
- Interface timing:
  - All outputs are registered.
  - The ROM is combinational, so the control word is valid in the same cycle as opcode, flags and step.
  - Every load takes effect at the next rising edge. One micro-step executes per clock.
- Bus:
  - Drivers: AOn → A; BOn → B; IOn → {4'h0, IR[3:0]}; COn → {4'h0, PC}; EOn → ALU result; ROn → RAM[MAR].
  - No driver asserted: bus = 8'h00.
  - Several drivers asserted: bus = bitwise OR of all asserted drivers.
- ALU (combinational on current A and B):
  - SU=0: {c, r} = A + B.
  - SU=1: {c, r} = A + ~B + 1.
  - carry = c; zero = (r == 0).
  - Flags update only when FIn is asserted.
- Loads:
  - AIn: A ← bus. BIn: B ← bus. OIn: OUT ← bus. IIn: IR ← bus. MIn: MAR ← bus[3:0]. RI: RAM[MAR] ← bus.
  - Loads use the pre-edge bus, so A can be both bus source and sink in one step.
  - RI and MIn in the same step: the write uses the old MAR.
- PC:
  - Jn: PC ← bus[3:0]. Jn has priority over CE.
  - CE alone: PC ← PC+1, wrapping from 15 to 0.
- Step counter:
  - NOn asserted: step ← 0.
  - Otherwise step ← step+1, wrapping from 3 to 0.
- HLT:
  - halted ← 1 at the edge where HLT is seen. All other loads in that same step still execute.
  - While halted, all CPU state and step are frozen and ctrl is ignored. Only rst clears halted.
- run=0:
  - CPU state and step are frozen and ctrl is ignored.
  - prog_we=1 writes RAM[prog_addr] ← prog_data.
  - prog_we is ignored while run=1.
- out_valid is high for exactly one cycle after each edge where OIn loaded OUT.

Optional Feature:
- Macro: BE8_BUS_CONFLICT_EN.
- Defined:
  - bus_conflict sets at any executing edge (run=1, not halted) where 2 or more bus drivers are asserted.
  - It stays set until rst.
- Undefined:
  - bus_conflict is tied to 0 and no detection logic is built.
  - Bus OR behaviour is unchanged in both builds.

Test Plan:
- Reset: assert rst 1 cycle mid-instruction with step=2, PC=9 → opcode=0, step=0, flags=00, out_data=0, halted=0 next cycle. Run RAM[3]=8'h5A check with RAM_INIT_ZERO=0 → 8'h5A survives reset.
- Fetch:
  - Load RAM[0]=8'h1E via the program port with run=0, then run=1.
  - Step 0 ctrl: MIn+COn. Step 1 ctrl: ROn+IIn+CE.
  - Expect opcode=1, IR[3:0]=E, PC=1, step=2.
- ALU:
  - A=8'hF0, B=8'h20, ctrl EOn+AIn+FIn → A=8'h10, flags=10.
  - A=5, B=5, ctrl SU+EOn+AIn+FIn → A=0, flags=11.
- Step and PC priority:
  - NOn at step 2 → step=0.
  - Step 3 without NOn → step=0.
  - Jn+CE with IOn driving IR=8'h07 → PC=7.
- Halt and output:
  - OIn with AOn, A=8'h2A → out_data=8'h2A, out_valid=1 for exactly 1 cycle.
  - HLT → halted=1; toggle ctrl randomly for 10 cycles → no state change.
  - rst → halted=0.
- Conflict (BE8_BUS_CONFLICT_EN build):
  - A=8'h0F, B=8'hF0, AOn+BOn+OIn → out_data=8'hFF, bus_conflict=1, remains set until rst.
  - Non-EN build: same stimulus → bus_conflict stays 0.
